// File: rtl/fact_pkg.sv
// Shared encodings and sizing for the factorial machine sequencer.
// Holds the state codes plus default counter/operand and accumulator widths.
package fact_pkg;

    localparam int CNT_W_DEF = 6;
    localparam int MAX_N_DEF = 20;
    localparam int ACC_W     = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_MUL   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/fact_cnt_6.sv
// Loadable down-counter holding the current factorial iteration value.
// Latency: load/decrement visible one edge after request; load wins over dec.
// Backpressure: none, the sequencer only decrements from a state that guarantees >= 2.
module fact_cnt_6 #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_nxt;

    always_comb begin
        w_nxt = r_cnt;
        if (i_load) begin
            w_nxt = i_load_val;
        end else if (i_dec) begin
            w_nxt = r_cnt - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fact_seq_ctrl.sv
// Factorial sequencer: init, multiply, decrement until n! sits in the accumulator.
// Latency: done 3n-1 edges after start (2 for n=0/1, immediate DONE on overflow).
// Backpressure: WAIT holds for mul_done; FACT_SEQ_CTRL_TIMEOUT_EN adds a WAIT watchdog.
module fact_seq_ctrl #(
    parameter int CNT_W = fact_pkg::CNT_W_DEF,
    parameter int MAX_N = fact_pkg::MAX_N_DEF
`ifdef FACT_SEQ_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 63
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [CNT_W-1:0] n_in,
    input  logic             mul_done,
    output logic             acc_init,
    output logic             mul_start,
    output logic [CNT_W-1:0] mul_op,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err,
    output logic [2:0]       state_o
);

    import fact_pkg::*;

    state_e           r_state;
    state_e           w_nxt;
    logic             r_ovf;
    logic             w_accept;
    logic             w_in_range;
    logic             w_load;
    logic             w_dec;
    logic [CNT_W-1:0] w_cnt;

    assign w_accept   = op_start && !op_clear &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_in_range = (n_in <= CNT_W'(MAX_N));
    assign w_load     = w_accept && w_in_range;

`ifdef FACT_SEQ_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wdog;
    logic            r_err;
    logic            w_to;
`endif

    always_comb begin
        w_nxt = ST_IDLE;
        w_dec = 1'b0;
`ifdef FACT_SEQ_CTRL_TIMEOUT_EN
        w_to  = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_nxt = r_state;
                if (w_accept) begin
                    w_nxt = w_in_range ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD:  w_nxt = ST_CHECK;
            ST_CHECK: w_nxt = (w_cnt <= CNT_W'(1)) ? ST_DONE : ST_MUL;
            ST_MUL:   w_nxt = ST_WAIT;
            ST_WAIT: begin
                w_nxt = ST_WAIT;
                if (mul_done) begin
                    w_nxt = ST_CHECK;
                    w_dec = 1'b1;
                end
`ifdef FACT_SEQ_CTRL_TIMEOUT_EN
                else if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                    w_nxt = ST_DONE;
                    w_to  = 1'b1;
                end
`endif
            end
            default:  w_nxt = ST_IDLE;
        endcase
        // Clear outranks every other request, including a mul_done in the same cycle.
        if (op_clear) begin
            w_nxt = ST_IDLE;
            w_dec = 1'b0;
`ifdef FACT_SEQ_CTRL_TIMEOUT_EN
            w_to  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (op_clear) begin
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                r_ovf <= !w_in_range;
            end
        end
    end

`ifdef FACT_SEQ_CTRL_TIMEOUT_EN
    // WAIT is only entered from MUL, so clearing there restarts the count per multiply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == ST_MUL) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            if (op_clear || w_accept) begin
                r_err <= 1'b0;
            end else if (w_to) begin
                r_err <= 1'b1;
            end
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    fact_cnt_6 #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (n_in),
        .o_cnt      (w_cnt)
    );

    assign acc_init  = (r_state == ST_LOAD);
    assign mul_start = (r_state == ST_MUL);
    assign mul_op    = w_cnt;
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_CHECK) ||
                       (r_state == ST_MUL)  || (r_state == ST_WAIT);
    assign done      = (r_state == ST_DONE);
    assign ovf       = r_ovf;
    assign state_o   = r_state;

endmodule

// File: doc/fact_seq_ctrl.md
Name: fact_seq_ctrl

Overview:
Sequencing controller for the factorial machine datapath. It owns the 6-bit iteration counter and drives the external accumulator/multiplier through init, multiply and decrement steps until n! is in the accumulator. It sits between the host command interface (start/clear) and the multiplier and accumulator datapath. All outputs are Moore, decoded from a registered state.

Parameters:
CNT_W, 6, iteration counter / operand width
MAX_N, 20, largest n accepted (20! is the largest factorial fitting a 64-bit accumulator)
TIMEOUT_CYC, 63, WAIT-state watchdog limit in cycles; used only with FACT_SEQ_CTRL_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
op_start  in  1  start request; sampled only in IDLE and DONE
op_clear  in  1  abort/clear; highest priority in every state
n_in  in  CNT_W  operand n, latched when op_start is accepted
mul_done  in  1  multiplier finished and accumulator written; honoured only in WAIT
acc_init  out  1  accumulator := 1 (asserted in LOAD)
mul_start  out  1  one-cycle multiply request (asserted in MUL)
mul_op  out  CNT_W  current counter value, multiplier operand
busy  out  1  high in LOAD, CHECK, MUL, WAIT
done  out  1  high in DONE
ovf  out  1  registered flag: n_in > MAX_N on last accepted start
err  out  1  watchdog error flag; tied 0 without the macro
state_o  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset (asynchronous, active-low, any time including mid-operation):
  - state goes to IDLE and the counter to 0.
  - ovf and err go to 0.
  - All outputs are 0.
- State encoding: IDLE=0, LOAD=1, CHECK=2, MUL=3, WAIT=4, DONE=5. Codes 6 and 7 return to IDLE on the next edge.
- IDLE, on op_start:
  - n_in <= MAX_N: counter := n_in, ovf := 0, go to LOAD.
  - n_in > MAX_N: ovf := 1, go directly to DONE. No acc_init is issued and the accumulator is left untouched.
- LOAD: acc_init=1 for one cycle, then go to CHECK.
- CHECK:
  - counter <= 1: go to DONE. This covers 0! = 1! = 1.
  - Otherwise: go to MUL.
- MUL: mul_start=1 and mul_op=counter for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold until mul_done=1.
  - On that edge the counter decrements by 1 and the state goes to CHECK.
  - mul_done may arrive in the first WAIT cycle.
- DONE:
  - done held high.
  - op_start: restart, identical to acceptance in IDLE.
  - op_clear: go to IDLE and clear ovf and err.
- op_clear in any state other than reset goes to IDLE on the next edge. It overrides op_start and mul_done in the same cycle. There is no accumulator side effect.
- op_start is ignored in LOAD, CHECK, MUL and WAIT.
- mul_done is ignored outside WAIT.
- mul_op is valid only while mul_start=1. Otherwise it shows the counter value.
- Latency (mul_done in the first WAIT cycle; edge 0 is the edge that samples op_start):
  - done is visible after 3n-1 edges for n >= 1, and after 2 edges for n = 0.
  - Overflow case: done after 1 edge.
- Counter never wraps: decrement happens only from CHECK with counter >= 2.

Optional Feature:
FACT_SEQ_CTRL_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without mul_done, go to DONE with err := 1.
  - err clears on op_clear or an accepted op_start.
- Not defined: no watchdog logic; err is constant 0; WAIT waits indefinitely.

Decomposition:
- Package fact_pkg holds:
  - state encoding constants (3-bit)
  - CNT_W = 6
  - MAX_N = 20
  - accumulator width 64
- Sub-module fact_cnt_6:
  - 6-bit loadable down-counter (load, dec) with asynchronous active-low reset.
  - Built on the team's 6-bit register with next-state muxing in front.

Test Plan:
- Reset mid-WAIT (n=5, mul_done withheld), drop reset_n -> state_o=0, busy=0, mul_start=0 immediately, without waiting for a clock edge.
- n_in=5, mul_done in first WAIT cycle -> mul_op sequence 5,4,3,2; exactly 4 mul_start pulses; done after 14 edges; single acc_init.
- n_in=0 and n_in=1 -> acc_init once, no mul_start, done after 2 edges, ovf=0.
- n_in=21 -> done after 1 edge, ovf=1, no acc_init; then op_clear -> IDLE, ovf=0.
- n_in=4 with mul_done delayed 7 cycles each, stray mul_done pulses in CHECK/MUL, op_start while busy -> strays ignored, 3 multiplies, n unchanged.
- Macro defined, TIMEOUT_CYC=63, n=3, mul_done never -> DONE with err=1 after 63 WAIT cycles; op_clear and op_clear+op_start in the same cycle both go to IDLE.
